melody_player: RTL and testbench

//  Parametrised, programmable successor of the fixed-tune beeper.

---
 rtl/melody_player.sv | 153 +++++++++++++++
 tb/tb_melody_player.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// Score-driven buzzer: plays {pitch, beats} entries from an internal RAM as a square wave,
// with an articulation gap at the end of each note, rests, loop mode and a done pulse.
module melody_player #(
  parameter int SCORE_DEPTH = 32,
  parameter int PER_W       = 18,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter logic [9*PER_W-1:0] PERIOD_LUT = {
    18'd95556, 18'd101214, 18'd113636, 18'd127551, 18'd143266,
    18'd151515, 18'd170068, 18'd191570, 18'd227272},
  localparam int AW = $clog2(SCORE_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          score_we,
  input  logic [AW-1:0] score_addr,
  input  logic [6:0]    score_data,
  input  logic [AW:0]   score_len,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx,
  output logic          beep
);

  localparam int NCW = $clog2(8 * BEAT_CYCLES) + 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state_q, state_d;
  logic [AW:0]        len_q, len_d;
  logic [AW-1:0]      note_idx_q, note_idx_d;
  logic [NCW-1:0]     note_cnt_q, note_cnt_d;
  logic [PER_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               beep_q, beep_d;

  logic [6:0]         score_mem [SCORE_DEPTH];
  logic [6:0]         cur_note, nxt_note;
  logic [NCW-1:0]     cur_cyc, nxt_cyc;
  logic [PER_W-1:0]   cur_per, nxt_per;
  logic               last_cycle, last_note;

  function automatic logic [PER_W-1:0] period_of(input logic [3:0] pitch);
    period_of = '0;
    for (int i = 1; i <= 9; i++) begin
      if (pitch == 4'(i)) period_of = PERIOD_LUT[(i-1)*PER_W +: PER_W];
    end
  endfunction

  function automatic logic [NCW-1:0] cycles_of(input logic [2:0] dur);
    cycles_of = (NCW'(dur) + NCW'(1)) * NCW'(BEAT_CYCLES);
  endfunction

  // The score is frozen while playing so the combinational reads stay coherent.
  always_ff @(posedge clk) begin
    if (score_we && !busy_q) score_mem[score_addr] <= score_data;
  end

  assign cur_note   = score_mem[note_idx_q];
  assign cur_cyc    = cycles_of(cur_note[2:0]);
  assign cur_per    = period_of(cur_note[6:3]);
  assign last_cycle = (note_cnt_q == cur_cyc - NCW'(1));
  assign last_note  = ({1'b0, note_idx_q} == len_q - (AW+1)'(1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    note_idx_d = note_idx_q;
    note_cnt_d = note_cnt_q;
    tone_cnt_d = tone_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (score_len != '0) begin
            state_d    = PLAY;
            len_d      = score_len;
            note_idx_d = '0;
            note_cnt_d = '0;
            tone_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_d    = IDLE;
          note_idx_d = '0;
          note_cnt_d = '0;
          tone_cnt_d = '0;
        end else if (last_cycle) begin
          note_cnt_d = '0;
          tone_cnt_d = '0;
          if (!last_note) begin
            note_idx_d = note_idx_q + AW'(1);
          end else if (loop_en) begin
            note_idx_d = '0;
          end else begin
            state_d    = IDLE;
            done_d     = 1'b1;
            note_idx_d = '0;
          end
        end else begin
          note_cnt_d = note_cnt_q + NCW'(1);
          if (cur_per == '0 || tone_cnt_q == cur_per - PER_W'(1)) tone_cnt_d = '0;
          else tone_cnt_d = tone_cnt_q + PER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so beep is derived from the note that will be sounding next cycle.
  assign nxt_note = score_mem[note_idx_d];
  assign nxt_cyc  = cycles_of(nxt_note[2:0]);
  assign nxt_per  = period_of(nxt_note[6:3]);
  assign busy_d   = (state_d == PLAY);
  assign beep_d   = busy_d && (nxt_per != '0) && (tone_cnt_d < (nxt_per >> 1))
                    && (note_cnt_d < nxt_cyc - NCW'(GAP_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      note_idx_q <= '0;
      note_cnt_q <= '0;
      tone_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      note_idx_q <= note_idx_d;
      note_cnt_q <= note_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      beep_q     <= beep_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = note_idx_q;
  assign beep     = beep_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: directed scenarios plus random scores checked cycle by cycle
// against a per-note expected waveform built from the score.
module tb_melody_player;

  localparam int BEAT = 8;
  localparam int GAP  = 2;
  localparam int PW   = 8;
  localparam logic [9*PW-1:0] LUT = {8'd12, 8'd3, 8'd10, 8'd9, 8'd8, 8'd7, 8'd5, 8'd6, 8'd4};

  logic       clk = 1'b0;
  logic       rst, score_we, loop_en, start, stop;
  logic [4:0] score_addr;
  logic [6:0] score_data;
  logic [5:0] score_len;
  logic       busy, done, beep;
  logic [4:0] note_idx;

  int errors = 0;
  int checks = 0;
  int tb_period [16];
  logic [6:0] ref_score [32];
  bit exp_beep[$];
  int exp_idx[$];

  melody_player #(
    .SCORE_DEPTH(32), .PER_W(PW), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .PERIOD_LUT(LUT)
  ) dut (
    .clk(clk), .rst(rst), .score_we(score_we), .score_addr(score_addr),
    .score_data(score_data), .score_len(score_len), .loop_en(loop_en),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .note_idx(note_idx), .beep(beep)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_note(input int addr, input int pitch, input int dur, input bit track);
    score_we = 1'b1;
    score_addr = 5'(addr);
    score_data = {4'(pitch), 3'(dur)};
    tick();
    score_we = 1'b0;
    if (track) ref_score[addr] = {4'(pitch), 3'(dur)};
  endtask

  // Expected per-cycle waveform: each note lasts (dur+1) beats, silent in its final GAP
  // cycles, otherwise high for the first half of every period (nothing for rests).
  task automatic build_expect(input int len);
    exp_beep.delete();
    exp_idx.delete();
    for (int n = 0; n < len; n++) begin
      int p, cyc, per;
      p   = int'(ref_score[n][6:3]);
      cyc = (int'(ref_score[n][2:0]) + 1) * BEAT;
      per = tb_period[p];
      for (int c = 0; c < cyc; c++) begin
        exp_beep.push_back(per != 0 && c < cyc - GAP && (c % per) < per / 2);
        exp_idx.push_back(n);
      end
    end
  endtask

  task automatic start_play(input int len, input bit lp);
    score_len = 6'(len);
    loop_en = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks `cycles` cycles of playback (wrapping through the model for loop mode).
  task automatic check_cycles(input string tag, input int cycles, input bit lp);
    for (int k = 0; k < cycles; k++) begin
      int j;
      j = k % exp_beep.size();
      check_eq({tag, " busy"}, int'(busy), 1);
      check_eq({tag, " beep"}, int'(beep), int'(exp_beep[j]));
      check_eq({tag, " idx"}, int'(note_idx), exp_idx[j]);
      if (lp) check_eq({tag, " done"}, int'(done), 0);
      tick();
    end
  endtask

  task automatic check_natural_end(input string tag);
    check_eq({tag, " end busy"}, int'(busy), 0);
    check_eq({tag, " end beep"}, int'(beep), 0);
    check_eq({tag, " end done"}, int'(done), 1);
    tick();
    check_eq({tag, " done width"}, int'(done), 0);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq({tag, " stop busy"}, int'(busy), 0);
    check_eq({tag, " stop beep"}, int'(beep), 0);
    check_eq({tag, " stop done"}, int'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tb_period[i] = 0;
    tb_period[1] = 4; tb_period[2] = 6; tb_period[3] = 5; tb_period[4] = 7;
    tb_period[5] = 8; tb_period[6] = 9; tb_period[7] = 10; tb_period[8] = 3;
    tb_period[9] = 12;
    rst = 1'b1; score_we = 1'b0; score_addr = '0; score_data = '0;
    score_len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    tick();
    tick();
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset beep", int'(beep), 0);
    check_eq("reset idx", int'(note_idx), 0);
    rst = 1'b0;
    tick();

    // 1: single one-beat note of period 4
    write_note(0, 1, 0, 1'b1);
    build_expect(1);
    start_play(1, 1'b0);
    check_cycles("s1", exp_beep.size(), 1'b0);
    check_natural_end("s1");

    // 2: looping tone + rest, two full passes then stop
    write_note(0, 2, 1, 1'b1);
    write_note(1, 0, 0, 1'b1);
    build_expect(2);
    start_play(2, 1'b1);
    check_cycles("s2", 2 * exp_beep.size() + 3, 1'b1);
    do_stop("s2");

    // 3: stop after 5 cycles of the same score
    start_play(2, 1'b1);
    check_cycles("s3", 5, 1'b1);
    do_stop("s3");
    tick();
    check_eq("s3 idle done", int'(done), 0);

    // 4: zero-length start
    start_play(0, 1'b0);
    check_eq("s4 busy", int'(busy), 0);
    check_eq("s4 done", int'(done), 1);
    tick();
    check_eq("s4 done width", int'(done), 0);

    // 5: writes while busy are dropped; start+stop together is ignored
    write_note(0, 1, 0, 1'b1);
    start_play(1, 1'b1);
    write_note(0, 9, 3, 1'b0);
    do_stop("s5");
    build_expect(1);
    start_play(1, 1'b0);
    check_cycles("s5", exp_beep.size(), 1'b0);
    check_natural_end("s5");
    score_len = 6'd1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check_eq("s5 start+stop busy", int'(busy), 0);
    check_eq("s5 start+stop done", int'(done), 0);

    // random scores, one-shot
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int n = 0; n < len; n++)
        write_note(n, $urandom_range(0, 15), $urandom_range(0, 7), 1'b1);
      build_expect(len);
      start_play(len, 1'b0);
      check_cycles($sformatf("rnd%0d", r), exp_beep.size(), 1'b0);
      check_natural_end($sformatf("rnd%0d", r));
    end

    // 6: asynchronous reset mid-note
    write_note(0, 1, 0, 1'b1);
    start_play(1, 1'b1);
    check_eq("s6 pre beep", int'(beep), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("s6 async beep", int'(beep), 0);
    check_eq("s6 async busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_eq("s6 idle busy", int'(busy), 0);
    check_eq("s6 idle beep", int'(beep), 0);
    check_eq("s6 idle done", int'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
